lcd_field_arbiter: RTL and testbench

LCD_FIELD_ARBITER -- requirements
Module: lcd_field_arbiter

---
 rtl/lcd_field_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lcd_field_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_field_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lcd_field_arbiter
// Purpose : Shares one character-LCD command channel between three display
//           fields (WAVE, RATE, DEPTH). Each field keeps a copy of what is
//           currently on the glass. A field whose input no longer matches
//           that copy is granted in round-robin order and repainted as one
//           DDRAM address byte followed by its characters.
// Ports   : clk        - single clock
//           rst        - asynchronous active-high reset
//           lcd_ready  - driver initialisation done; gates new grants
//           shape[2:0] - waveform select (WAVE field)
//           depth[2:0] - modulation depth (DEPTH field)
//           freq[7:0]  - rate in BPM (RATE field)
//           cmd_valid  - command byte offered to the LCD driver
//           cmd_ready  - driver accepts the byte (valid & ready = transfer)
//           cmd_rs     - 0 instruction, 1 character data
//           cmd_data   - command byte
//           grant[2:0] - one-hot active field: bit0 WAVE, bit1 RATE, bit2 DEPTH
//           busy       - high whenever the FSM is not IDLE
// Build   : define LCD_ARB_REFRESH_EN to add a periodic full repaint every
//           REFRESH_CYCLES clocks; without it no refresh counter exists.
// Rev     : 1.0 - initial release
// ============================================================================
module lcd_field_arbiter #(
    parameter logic [6:0]  WAVE_ADDR      = 7'h46,
    parameter logic [6:0]  RATE_ADDR      = 7'h16,
    parameter logic [6:0]  DEPTH_ADDR     = 7'h56,
    parameter int unsigned REFRESH_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_ready,
    input  logic [2:0] shape,
    input  logic [2:0] depth,
    input  logic [7:0] freq,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic [2:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        CHARS = 2'd2
    } state_t;

    state_t     state;

    // Copies of what is currently painted, plus a valid bit per field.
    logic [2:0] shown_wave;
    logic [7:0] shown_rate;
    logic [2:0] shown_depth;
    logic [2:0] shown_valid;

    // Field index where the next round-robin search starts (0 WAVE .. 2 DEPTH).
    logic [1:0] rr_ptr;

    // Index of the next character to load into cmd_data.
    logic [2:0] idx;

    logic [2:0] pending;
    logic       sel_found;
    logic [1:0] sel_field;
    logic [2:0] sel_mask;
    logic [6:0] sel_addr;
    logic [7:0] next_char;
    logic [2:0] field_len;
    logic [3:0] rate_hund;
    logic [3:0] rate_tens;
    logic [3:0] rate_ones;
    logic       refresh_clear;
    logic       xfer;

    assign xfer = cmd_valid & cmd_ready;
    assign busy = (state != IDLE);

    assign pending[0] = !shown_valid[0] || (shape != shown_wave);
    assign pending[1] = !shown_valid[1] || (freq  != shown_rate);
    assign pending[2] = !shown_valid[2] || (depth != shown_depth);

    // ------------------------------------------------------------------------
    // Round-robin pick: first pending field starting at rr_ptr.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [1:0] cand;
        sel_found = 1'b0;
        sel_field = 2'd0;
        cand      = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_field = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    assign sel_mask = 3'b001 << sel_field;

    always_comb begin
        case (sel_field)
            2'd0:    sel_addr = WAVE_ADDR;
            2'd1:    sel_addr = RATE_ADDR;
            default: sel_addr = DEPTH_ADDR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Character generation from the snapshot (never from live inputs), so an
    // input change mid-write cannot corrupt the field being painted.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] wave_char(input logic [2:0] sel, input logic [2:0] i);
        logic [47:0] s;
        case (sel)
            3'd0:    s = "SINE  ";
            3'd1:    s = "SQUARE";
            3'd2:    s = "TRI   ";
            3'd3:    s = "SAW   ";
            3'd4:    s = "RAMP  ";
            3'd5:    s = "NOISE ";
            default: s = "------";
        endcase
        case (i)
            3'd0:    return s[47:40];
            3'd1:    return s[39:32];
            3'd2:    return s[31:24];
            3'd3:    return s[23:16];
            3'd4:    return s[15:8];
            3'd5:    return s[7:0];
            default: return 8'h20;
        endcase
    endfunction

    assign rate_hund = 4'(shown_rate / 8'd100);
    assign rate_tens = 4'((shown_rate / 8'd10) % 8'd10);
    assign rate_ones = 4'(shown_rate % 8'd10);

    always_comb begin
        next_char = 8'h20;
        field_len = 3'd0;
        case (grant)
            3'b001: begin
                field_len = 3'd6;
                next_char = wave_char(shown_wave, idx);
            end
            3'b010: begin
                field_len = 3'd3;
                case (idx)
                    3'd0:    next_char = (rate_hund == 4'd0) ? 8'h20 : {4'h3, rate_hund};
                    3'd1:    next_char = (rate_hund == 4'd0 && rate_tens == 4'd0)
                                         ? 8'h20 : {4'h3, rate_tens};
                    default: next_char = {4'h3, rate_ones};
                endcase
            end
            3'b100: begin
                field_len = 3'd7;
                next_char = (idx < shown_depth) ? 8'hDB : 8'h20;
            end
            default: begin
                field_len = 3'd0;
                next_char = 8'h20;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional periodic repaint.
    // ------------------------------------------------------------------------
`ifdef LCD_ARB_REFRESH_EN
    localparam int unsigned REFRESH_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

    logic [REFRESH_W-1:0] refresh_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign refresh_clear = (refresh_cnt == REFRESH_LAST);
`else
    // REFRESH_CYCLES has no effect in this build; it stays in the parameter
    // list so both builds share one instantiation.
    assign refresh_clear = 1'b0 & (REFRESH_CYCLES == 0);
`endif

    // ------------------------------------------------------------------------
    // Main FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_valid   <= 1'b0;
            cmd_rs      <= 1'b0;
            cmd_data    <= 8'h00;
            grant       <= 3'b000;
            idx         <= 3'd0;
            rr_ptr      <= 2'd0;
            shown_wave  <= 3'd0;
            shown_rate  <= 8'd0;
            shown_depth <= 3'd0;
            shown_valid <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (lcd_ready && sel_found) begin
                        state       <= ADDR;
                        grant       <= sel_mask;
                        shown_valid <= shown_valid | sel_mask;
                        rr_ptr      <= (sel_field == 2'd2) ? 2'd0 : sel_field + 2'd1;
                        if (sel_mask[0]) shown_wave  <= shape;
                        if (sel_mask[1]) shown_rate  <= freq;
                        if (sel_mask[2]) shown_depth <= depth;
                        idx         <= 3'd0;
                        cmd_valid   <= 1'b1;
                        cmd_rs      <= 1'b0;
                        cmd_data    <= {1'b1, sel_addr};
                    end
                end

                ADDR: begin
                    if (xfer) begin
                        state    <= CHARS;
                        cmd_rs   <= 1'b1;
                        cmd_data <= next_char;
                        idx      <= idx + 3'd1;
                    end
                end

                CHARS: begin
                    if (xfer) begin
                        if (idx == field_len) begin
                            // Last character just went out.
                            state     <= IDLE;
                            cmd_valid <= 1'b0;
                            cmd_rs    <= 1'b0;
                            cmd_data  <= 8'h00;
                            grant     <= 3'b000;
                            idx       <= 3'd0;
                        end else begin
                            cmd_data <= next_char;
                            idx      <= idx + 3'd1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                    cmd_rs    <= 1'b0;
                    cmd_data  <= 8'h00;
                    grant     <= 3'b000;
                    idx       <= 3'd0;
                end
            endcase

            // A refresh that coincides with a grant wins; that field is simply
            // painted once more afterwards.
            if (refresh_clear) begin
                shown_valid <= 3'b000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_field_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_lcd_field_arbiter
// Purpose : Scoreboard bench for lcd_field_arbiter. Expected {grant,rs,data}
//           words are queued when stimulus is applied and compared against
//           each transfer seen on the command channel.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_lcd_field_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_ready = 1'b0;
    logic [2:0] shape = 3'd1;
    logic [2:0] depth = 3'd3;
    logic [7:0] freq  = 8'd100;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic [2:0] grant;
    logic       busy;

    lcd_field_arbiter #(
        .WAVE_ADDR      (7'h46),
        .RATE_ADDR      (7'h16),
        .DEPTH_ADDR     (7'h56),
        .REFRESH_CYCLES (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_ready (lcd_ready),
        .shape     (shape),
        .depth     (depth),
        .freq      (freq),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];
    logic [2:0]  prev_grant = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push_byte(input logic [2:0] g, input logic rs, input logic [7:0] d);
        exp_q.push_back({g, rs, d});
    endfunction

    function automatic void push_wave(input int s);
        string str;
        case (s)
            0: str = "SINE  ";
            1: str = "SQUARE";
            2: str = "TRI   ";
            3: str = "SAW   ";
            4: str = "RAMP  ";
            5: str = "NOISE ";
            default: str = "------";
        endcase
        push_byte(3'b001, 1'b0, 8'hC6);
        for (int i = 0; i < 6; i++) push_byte(3'b001, 1'b1, str[i]);
    endfunction

    function automatic void push_rate(input int f);
        int h, t, o;
        h = f / 100;
        t = (f / 10) % 10;
        o = f % 10;
        push_byte(3'b010, 1'b0, 8'h96);
        push_byte(3'b010, 1'b1, (h == 0) ? 8'h20 : 8'(48 + h));
        push_byte(3'b010, 1'b1, (h == 0 && t == 0) ? 8'h20 : 8'(48 + t));
        push_byte(3'b010, 1'b1, 8'(48 + o));
    endfunction

    function automatic void push_depth(input int d);
        push_byte(3'b100, 1'b0, 8'hD6);
        for (int i = 0; i < 7; i++) push_byte(3'b100, 1'b1, (i < d) ? 8'hDB : 8'h20);
    endfunction

    // Transfer monitor: sampled on the falling edge, the transfer itself
    // happens on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_byte", {20'd0, grant, cmd_rs, cmd_data}, 32'd0);
                else
                    check("byte", {20'd0, grant, cmd_rs, cmd_data}, {20'd0, exp_q.pop_front()});
            end
            if (cmd_valid)
                check("busy_while_valid", busy, 1);
            if (grant != 3'b000 && prev_grant != 3'b000)
                check("grant_no_switch", grant, prev_grant);
        end
        prev_grant = grant;
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int active;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_rs",    cmd_rs,    0);
        check("rst_cmd_data",  cmd_data,  0);
        check("rst_grant",     grant,     0);
        check("rst_busy",      busy,      0);

        // Initial paint, gated by lcd_ready.
        push_wave(1); push_rate(100); push_depth(3);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_grant_unready", busy, 0);
        end
        @(posedge clk); #1;
        lcd_ready = 1'b1;
        wait_drain("paint", 200);

        // Two fields change together while idle: WAVE then DEPTH.
        push_wave(4); push_depth(5);
        shape = 3'd4; depth = 3'd5;
        wait_drain("dual", 200);

        // Back-pressure during ADDR.
        cmd_ready = 1'b0;
        push_wave(2);
        shape = 3'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_valid && n < 20);
        check("stall_offer_seen", cmd_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", cmd_valid, 1);
            check("stall_rs",    cmd_rs,    0);
            check("stall_data",  cmd_data,  8'hC6);
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wait_drain("stall", 200);

        // freq changes while RATE characters are in flight.
        push_rate(50);
        freq = 8'd50;
        wait_drain("rate50", 200);
        push_rate(100);
        freq = 8'd100;
        n = 0;
        do begin @(negedge clk); n++; end while (!(grant == 3'b010 && cmd_rs) && n < 50);
        check("rate_inflight_seen", {grant, cmd_rs}, {3'b010, 1'b1});
        @(posedge clk); #1;
        push_rate(7);
        freq = 8'd7;
        wait_drain("rate7", 200);

        // Reset during DEPTH characters.
        push_depth(1);
        depth = 3'd1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(grant == 3'b100 && cmd_rs) && n < 50);
        check("depth_inflight_seen", {grant, cmd_rs}, {3'b100, 1'b1});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_cmd_valid", cmd_valid, 0);
        check("midrst_grant",     grant,     0);
        check("midrst_busy",      busy,      0);
        check("midrst_cmd_data",  cmd_data,  0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        push_wave(2); push_rate(7); push_depth(1);
        rst = 1'b0;
        wait_drain("repaint", 200);

        // Static inputs after the paint.
`ifdef LCD_ARB_REFRESH_EN
        push_wave(2); push_rate(7); push_depth(1);
        wait_drain("refresh", 1200);
`else
        active = 0;
        repeat (1200) begin
            @(negedge clk);
            if (cmd_valid) active++;
        end
        check("idle_after_paint", active, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
